// File: rtl/exc_pkg.sv
// Shared definitions for the exception/ERTN commit controller.
// Holds the FSM state encoding, the field widths of the exception code and
// subcode, and the code reported for interrupts.
package exc_pkg;

    localparam int ECODE_W = 6;
    localparam int ESUB_W  = 9;

    localparam logic [ECODE_W-1:0] ECODE_INT    = 6'h0;
    localparam logic [ESUB_W-1:0]  ESUBCODE_INT = 9'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_REDIR  = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_ctrl.sv
// Exception / interrupt / ERTN commit controller at the writeback stage.
// Latency: event accepted on edge N, commit strobe during cycle N+1,
// redirect offered from cycle N+2 until redir_ready; next accept is 3 cycles
// after the previous one at best. Backpressure: ws_allow drops while busy and
// the redirect is held (valid, pc stable) until fetch takes it.
// Optional feature: define EXC_CTRL_INT_EN to take interrupts (has_int);
// without it has_int is ignored and ecode 6'h0 is never produced.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   ws_valid/ws_ex/ws_ertn          retiring instruction and its event flags
//   ws_ecode/ws_esubcode/ws_pc/ws_vaddr  event fields from writeback
//   has_int                         pending enabled interrupt
//   csr_eentry/csr_era              redirect targets from the CSR file
//   ws_allow                        writeback may retire (IDLE only)
//   wb_ex/ertn_flush + wb_*         one-cycle commit to the CSR file
//   flush                           kill younger instructions while busy
//   redir_valid/redir_ready/redir_pc  redirect to fetch
module exc_ctrl
    import exc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ws_valid,
    input  logic               ws_ex,
    input  logic [ECODE_W-1:0] ws_ecode,
    input  logic [ESUB_W-1:0]  ws_esubcode,
    input  logic [31:0]        ws_pc,
    input  logic [31:0]        ws_vaddr,
    input  logic               ws_ertn,
    input  logic               has_int,
    input  logic [31:0]        csr_eentry,
    input  logic [31:0]        csr_era,
    output logic               ws_allow,
    output logic               wb_ex,
    output logic               ertn_flush,
    output logic [ECODE_W-1:0] wb_ecode,
    output logic [ESUB_W-1:0]  wb_esubcode,
    output logic [31:0]        wb_pc,
    output logic [31:0]        wb_vaddr,
    output logic               flush,
    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [31:0]        redir_pc
);

    exc_state_t state, state_nxt;

    logic take_int;
    logic take_exc;
    logic take_ertn;
    logic take_any;
    logic ertn_q;     // accepted event was ERTN (selects strobe and target)

`ifdef EXC_CTRL_INT_EN
    assign take_int = ws_valid & has_int;
`else
    logic unused_has_int;
    assign unused_has_int = has_int;
    assign take_int       = 1'b0;
`endif

    // Priority INT > EXC > ERTN; exactly one event is taken.
    assign take_exc  = ws_valid & ws_ex & ~take_int;
    assign take_ertn = ws_valid & ws_ertn & ~ws_ex & ~take_int;
    assign take_any  = take_int | take_exc | take_ertn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All control outputs decode from state alone, so an async reset
    // drops them immediately without waiting for an edge.
    always_comb begin
        state_nxt   = state;
        ws_allow    = 1'b0;
        wb_ex       = 1'b0;
        ertn_flush  = 1'b0;
        flush       = 1'b0;
        redir_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                ws_allow = 1'b1;
                if (take_any) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                flush      = 1'b1;
                wb_ex      = ~ertn_q;
                ertn_flush = ertn_q;
                state_nxt  = ST_REDIR;
            end
            ST_REDIR: begin
                flush       = 1'b1;
                redir_valid = 1'b1;
                if (redir_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Event fields are captured only on the accept edge and then held, so
    // the wb_* data ports keep their last value outside COMMIT. ERTN carries
    // no exception fields and leaves them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ertn_q      <= 1'b0;
            wb_ecode    <= '0;
            wb_esubcode <= '0;
            wb_pc       <= '0;
            wb_vaddr    <= '0;
            redir_pc    <= '0;
        end else begin
            if (state == ST_IDLE && take_any) begin
                ertn_q <= take_ertn;
                if (!take_ertn) begin
                    wb_ecode    <= take_int ? ECODE_INT    : ws_ecode;
                    wb_esubcode <= take_int ? ESUBCODE_INT : ws_esubcode;
                    wb_pc       <= ws_pc;
                    wb_vaddr    <= ws_vaddr;
                end
            end
            // Target is sampled from the CSR file during COMMIT and then
            // held stable for the whole redirect handshake.
            if (state == ST_COMMIT) begin
                redir_pc <= ertn_q ? csr_era : csr_eentry;
            end
        end
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: ws_valid  input  1  writeback-stage instruction retiring this cycle.
REQ-004 SHALL have: ws_ex  input  1  retiring instruction raised a synchronous exception.
REQ-005 SHALL have: ws_ecode  input  6  / ws_esubcode  input  9  exception code/subcode.
REQ-006 SHALL have: ws_pc  input  32  / ws_vaddr  input  32  PC and faulting address of the retiring instruction.
REQ-007 SHALL have: ws_ertn  input  1  retiring instruction is ERTN.
REQ-008 SHALL have: has_int  input  1  enabled interrupt pending, from the CSR file.
REQ-009 SHALL have: csr_eentry  input  32  / csr_era  input  32  exception entry and return address, from the CSR file.
REQ-010 SHALL have: ws_allow  output  1  writeback may retire; 0 whenever the FSM is not IDLE.
REQ-011 SHALL have: wb_ex, ertn_flush  output  1 each; wb_ecode 6, wb_esubcode 9, wb_pc 32, wb_vaddr 32  output  CSR-file commit port.
REQ-012 SHALL have: flush  output  1  kill all younger pipeline instructions.
REQ-013 SHALL have: redir_valid  output  1 / redir_ready  input  1 / redir_pc  output  32  valid/ready redirect to fetch.

Function
REQ-014 SHALL implement FSM IDLE -> COMMIT -> REDIR -> IDLE.
REQ-015 SHALL accept an event in IDLE only when ws_valid=1; the event is one of INT (has_int=1), EXC (ws_ex=1), or ERTN (ws_ertn=1).
REQ-016 SHALL resolve simultaneous events with priority INT > EXC > ERTN; only one event is taken.
REQ-017 SHALL, for INT, use ecode 6'h0, esubcode 0, wb_pc=ws_pc; the instruction does not retire.
REQ-018 SHALL register the accepted event's fields on the accept edge and move to COMMIT.
REQ-019 SHALL, in COMMIT, assert exactly one of wb_ex or ertn_flush for exactly one cycle, with the registered fields on the wb_* ports.
REQ-020 SHALL, in COMMIT, latch redir_pc = csr_eentry for INT/EXC or csr_era for ERTN, then move to REDIR.
REQ-021 SHALL, in REDIR, hold redir_valid=1 with redir_pc stable until the cycle redir_ready=1, then return to IDLE.
REQ-022 SHALL assert flush in COMMIT and REDIR and deassert it in IDLE.
REQ-023 SHALL ignore ws_valid, has_int, ws_ex and ws_ertn while not IDLE.
REQ-024 SHALL give a minimum event-to-event spacing of 3 cycles (accept, COMMIT, REDIR with ready=1).
REQ-025 SHALL hold wb_* data ports at their last value outside COMMIT; only the wb_ex and ertn_flush strobes gate them.

Reset
REQ-026 SHALL, on reset, immediately return the FSM to IDLE, including mid-COMMIT and mid-REDIR.
REQ-027 SHALL reset outputs to: wb_ex=0, ertn_flush=0, flush=0, redir_valid=0, ws_allow=1, redir_pc=0, wb_*=0.

Configuration
REQ-028 SHALL, with EXC_CTRL_INT_EN defined, take INT events as specified above.
REQ-029 SHALL, without EXC_CTRL_INT_EN, ignore has_int, so that ecode 6'h0 is never generated by this block.

Structure
REQ-030 SHALL place the FSM state encoding, ECODE_INT=6'h0, and the ecode/esubcode width constants in shared package exc_pkg.
REQ-031 SHALL be a single flat module; a sub-module is not warranted.

Verification
REQ-032 SHALL cover: ws_valid=1, ws_ex=1, ecode=6'h9, pc=32'h1c000100, vaddr=32'h3 -> one-cycle wb_ex with those values next cycle; redir_pc=csr_eentry.
REQ-033 SHALL cover: ws_ertn=1, csr_era=32'h1c000200 -> one-cycle ertn_flush; redir_valid with redir_pc=32'h1c000200.
REQ-034 SHALL cover: has_int=1 and ws_ex=1 in the same cycle (macro on) -> wb_ecode=0, single wb_ex pulse, no second event.
REQ-035 SHALL cover: redir_ready held 0 for 5 cycles -> redir_valid, flush and redir_pc stable; ws_allow=0; new ws_valid events dropped.
REQ-036 SHALL cover: reset asserted in REDIR -> redir_valid and flush fall without waiting for a clock edge; ws_allow=1.
REQ-037 SHALL cover: macro off, has_int=1 with ws_valid=1 and no other event -> no wb_ex, no flush, FSM stays IDLE.
